// File: rtl/axi_ni_request_scheduler.sv
// Round-robin (ID, read/write) scheduler for the AXI initiator NI request path.
// Tracks per-ID outstanding reads/writes and keeps each ID on a single destination.
module axi_ni_request_scheduler #(
    parameter int MAX_SUPPORTED_IDS = 16,
    parameter logic [MAX_SUPPORTED_IDS-1:0] ID_MAP = '1,
    parameter int LOG_MAX_OUTS_WR = 4,
    parameter int LOG_MAX_OUTS_RD = 2,
    parameter int DESTWD = 8,
    parameter int IDWD = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MAX_SUPPORTED_IDS-1:0]        aw_rempty,
    input  logic [MAX_SUPPORTED_IDS-1:0]        ar_rempty,
    input  logic [MAX_SUPPORTED_IDS-1:0]        wd_rempty,
    input  logic [MAX_SUPPORTED_IDS*DESTWD-1:0] aw_dest,
    input  logic [MAX_SUPPORTED_IDS*DESTWD-1:0] ar_dest,
    input  logic [MAX_SUPPORTED_IDS-1:0]        decr_wr,
    input  logic [MAX_SUPPORTED_IDS-1:0]        decr_rd,
    output logic                                grant_valid,
    output logic [IDWD-1:0]                     grant_id,
    output logic                                grant_write,
    input  logic                                grant_ready,
    output logic [MAX_SUPPORTED_IDS-1:0]        aw_rinc,
    output logic [MAX_SUPPORTED_IDS-1:0]        ar_rinc,
    output logic [MAX_SUPPORTED_IDS-1:0]        response_awaited,
    output logic                                err_unfl
);

    localparam int N  = MAX_SUPPORTED_IDS;
    localparam int NS = 2 * N;
    localparam int PW = $clog2(NS);
    localparam int LW = LOG_MAX_OUTS_WR;
    localparam int LR = LOG_MAX_OUTS_RD;
    localparam logic [LW:0] WR_MAX = {1'b1, {LW{1'b0}}};
    localparam logic [LR:0] RD_MAX = {1'b1, {LR{1'b0}}};
    localparam logic [LW:0] WR_ONE = 1;
    localparam logic [LR:0] RD_ONE = 1;

    logic [LW:0]       wr_cnt_q  [N];
    logic [LW:0]       wr_cnt_d  [N];
    logic [LR:0]       rd_cnt_q  [N];
    logic [LR:0]       rd_cnt_d  [N];
    logic [DESTWD-1:0] wr_dest_q [N];
    logic [DESTWD-1:0] wr_dest_d [N];
    logic [DESTWD-1:0] rd_dest_q [N];
    logic [DESTWD-1:0] rd_dest_d [N];

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            grant_valid_q;
    logic [IDWD-1:0] grant_id_q;
    logic            grant_write_q;
    logic            err_q, err_d;

    logic [NS-1:0] elig;
    logic [N-1:0]  wr_inc, wr_dec, rd_inc, rd_dec;
    logic          hs;
    logic          win_found;
    logic [PW-1:0] win_slot;
    logic [PW:0]   idx;
    int            gs;

    assign hs = grant_valid_q & grant_ready;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[2*i] = ID_MAP[i] && !aw_rempty[i] && !wd_rempty[i]
                && (wr_cnt_q[i] < WR_MAX)
                && ((wr_cnt_q[i] == '0)
                    || (wr_dest_q[i] == aw_dest[i*DESTWD +: DESTWD]));
            elig[2*i+1] = ID_MAP[i] && !ar_rempty[i]
                && (rd_cnt_q[i] < RD_MAX)
                && ((rd_cnt_q[i] == '0)
                    || (rd_dest_q[i] == ar_dest[i*DESTWD +: DESTWD]));
        end
    end

    // First eligible slot at or after ptr, wrapping modulo 2N
    always_comb begin
        win_found = 1'b0;
        win_slot  = '0;
        idx       = '0;
        for (int k = 0; k < NS; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NS)) begin
                idx = idx - (PW+1)'(NS);
            end
            if (!win_found && elig[idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_slot  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        gs = 2 * int'(grant_id_q) + (grant_write_q ? 1 : 2);
        if (gs >= NS) begin
            gs = gs - NS;
        end
        ptr_d = PW'(gs);
    end

    always_comb begin
        err_d  = err_q;
        wr_inc = '0;
        wr_dec = '0;
        rd_inc = '0;
        rd_dec = '0;
        for (int i = 0; i < N; i++) begin
            wr_inc[i] = hs && grant_write_q && (grant_id_q == IDWD'(i));
            rd_inc[i] = hs && !grant_write_q && (grant_id_q == IDWD'(i));
            wr_dec[i] = decr_wr[i] && ID_MAP[i] && (wr_cnt_q[i] != '0);
            rd_dec[i] = decr_rd[i] && ID_MAP[i] && (rd_cnt_q[i] != '0);
            if ((decr_wr[i] && ID_MAP[i] && (wr_cnt_q[i] == '0))
                || (decr_rd[i] && ID_MAP[i] && (rd_cnt_q[i] == '0))) begin
                err_d = 1'b1;
            end
            wr_cnt_d[i] = wr_cnt_q[i];
            if (wr_inc[i] && !wr_dec[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] + WR_ONE;
            end else if (!wr_inc[i] && wr_dec[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] - WR_ONE;
            end
            rd_cnt_d[i] = rd_cnt_q[i];
            if (rd_inc[i] && !rd_dec[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + RD_ONE;
            end else if (!rd_inc[i] && rd_dec[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] - RD_ONE;
            end
            wr_dest_d[i] = wr_inc[i] ? aw_dest[i*DESTWD +: DESTWD]
                                     : wr_dest_q[i];
            rd_dest_d[i] = rd_inc[i] ? ar_dest[i*DESTWD +: DESTWD]
                                     : rd_dest_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_write_q <= 1'b0;
            ptr_q         <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < N; i++) begin
                wr_cnt_q[i]  <= '0;
                rd_cnt_q[i]  <= '0;
                wr_dest_q[i] <= '0;
                rd_dest_q[i] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < N; i++) begin
                wr_cnt_q[i]  <= wr_cnt_d[i];
                rd_cnt_q[i]  <= rd_cnt_d[i];
                wr_dest_q[i] <= wr_dest_d[i];
                rd_dest_q[i] <= rd_dest_d[i];
            end
            // Drop for a cycle after each handshake so state settles
            if (hs) begin
                grant_valid_q <= 1'b0;
                ptr_q         <= ptr_d;
            end else if (!grant_valid_q && win_found) begin
                grant_valid_q <= 1'b1;
                grant_id_q    <= IDWD'(win_slot >> 1);
                grant_write_q <= ~win_slot[0];
            end
        end
    end

    always_comb begin
        response_awaited = '0;
        for (int i = 0; i < N; i++) begin
            response_awaited[i] = (wr_cnt_q[i] != '0) || (rd_cnt_q[i] != '0);
        end
    end

    assign aw_rinc = (hs && grant_write_q)
                   ? (N'(1) << grant_id_q) : '0;
    assign ar_rinc = (hs && !grant_write_q)
                   ? (N'(1) << grant_id_q) : '0;

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign grant_write = grant_write_q;
    assign err_unfl    = err_q;

endmodule

// File: doc/axi_ni_request_scheduler.md
Name: axi_ni_request_scheduler

Overview:
Parametrised transaction scheduler for the AXI initiator NI request path. It sits between the per-ID AW/AR/W FIFOs and the request packetizer FSM, and picks the next (ID, read/write) transaction with round-robin arbitration. It tracks outstanding transactions per ID with independent read and write depths. Unlike the previous single-outstanding-read scheme, it allows multiple outstanding transactions per ID as long as they all target the same destination.

Parameters:
MAX_SUPPORTED_IDS, 16, number of AXI IDs (N)
ID_MAP, all-ones (N bits), bit i=1 means ID i is implemented; unmapped IDs are never granted
LOG_MAX_OUTS_WR, 4, max outstanding writes per ID = 2^LOG_MAX_OUTS_WR
LOG_MAX_OUTS_RD, 2, max outstanding reads per ID = 2^LOG_MAX_OUTS_RD
DESTWD, 8, destination tag width (routing LUT index)
IDWD, 4, grant_id width, must satisfy 2^IDWD >= N

Ports:
clk  in  1  NoC-side clock
rst  in  1  synchronous, active-low reset
aw_rempty  in  N  per-ID AW FIFO empty
ar_rempty  in  N  per-ID AR FIFO empty
wd_rempty  in  N  per-ID W FIFO empty
aw_dest  in  N*DESTWD  destination tag of each AW FIFO head; ID i at [i*DESTWD +: DESTWD]
ar_dest  in  N*DESTWD  destination tag of each AR FIFO head
decr_wr  in  N  one-cycle pulse per write response retired
decr_rd  in  N  one-cycle pulse per read response retired
grant_valid  out  1  scheduled transaction available
grant_id  out  IDWD  ID of granted transaction
grant_write  out  1  1 = write, 0 = read
grant_ready  in  1  packetizer accepts the grant
aw_rinc  out  N  one-hot pop of AW FIFO
ar_rinc  out  N  one-hot pop of AR FIFO
response_awaited  out  N  bit i = (wr_cnt[i] != 0) or (rd_cnt[i] != 0)
err_unfl  out  1  sticky: a decrement arrived with the counter at 0

Behaviour:
- Reset (rst=0 at a clk edge): grant_valid=0, grant_id=0, grant_write=0, all counters=0, dest registers=0, round-robin pointer=0, err_unfl=0. aw_rinc/ar_rinc=0 because they are combinational from the handshake.
- Requester slots: 2N, ordered slot 2i = write ID i, slot 2i+1 = read ID i.
- Write slot i is eligible when all hold:
  - ID_MAP[i] = 1
  - !aw_rempty[i] and !wd_rempty[i]
  - wr_cnt[i] < 2^LOG_MAX_OUTS_WR
  - wr_cnt[i] == 0 or wr_dest[i] == aw_dest[i]
- Read slot i is eligible under the same rules using ar_rempty, rd_cnt, rd_dest, ar_dest and 2^LOG_MAX_OUTS_RD. Read eligibility does not depend on wd_rempty.
- Arbitration: round-robin. Search starts at slot ptr and wraps modulo 2N; the first eligible slot wins.
- Grant is registered. When grant_valid=0 and at least one slot is eligible at edge t, grant_valid=1 from t with grant_id/grant_write set to the winner. Latency: 1 cycle from eligibility to grant_valid.
- Hold rule: while grant_valid && !grant_ready, grant_id and grant_write stay stable regardless of eligibility changes.
- Handshake cycle (grant_valid && grant_ready):
  - aw_rinc[id] or ar_rinc[id] = 1 combinationally in that cycle.
  - At the edge: the matching counter increments and the dest register loads the head dest tag; ptr = granted slot + 1 (mod 2N); grant_valid = 0.
- Throughput: grant_valid is always low for at least one cycle after a handshake, so eligibility is re-evaluated on updated state. Maximum rate is one grant per 2 cycles.
- Counter width is LOG+1 bits per counter.
- Simultaneous increment and decrement on the same counter: count unchanged; dest register still loads.
- Decrement with counter at 0: counter stays 0 and err_unfl is set until reset. decr on an unmapped ID is ignored.
- Overflow cannot occur because of the eligibility rules.
- Dest registers keep their value when a counter returns to 0; the value is ignored while the count is 0.
- No combinational path from grant_ready to grant_valid, grant_id or grant_write.
- A reset asserted mid-grant drops grant_valid at that edge; in-flight counts are lost.

Test Plan:
1. Write eligible but wd_rempty=1: ID2 AW non-empty, W empty, grant_ready=1 -> grant_valid stays 0. Clear wd_rempty[2] -> grant_valid=1, grant_id=2, grant_write=1 one cycle later; aw_rinc=0x0004 in the handshake cycle; response_awaited[2]=1.
2. Round-robin: IDs 0,1,3 all have reads pending, grant_ready tied to 1 -> grant order ID0, ID1, ID3, ID0 with a 1-cycle gap between grants. After ID3, ptr = slot 8.
3. Same-destination reads with LOG_MAX_OUTS_RD=2, ID5, ar_dest=0x11 constant -> 4 reads granted, the 5th blocked. One decr_rd[5] pulse -> the 5th is granted.
4. Destination switch: ID5 has one read outstanding to dest 0x11, next head is dest 0x22 -> blocked until decr_rd[5]. Meanwhile a write on ID5 to 0x22 is granted.
5. Stall: grant_valid=1 (ID1, read), grant_ready=0 for 5 cycles while ID0 becomes eligible -> grant_id stays 1 and ar_rinc stays 0 until grant_ready=1.
6. Boundaries:
   - decr_wr[7] with wr_cnt[7]=0 -> err_unfl=1 and stays set.
   - Simultaneous handshake and decr on the same ID/counter -> count unchanged.
   - rst=0 while grant_valid=1 -> grant_valid=0 and all counters 0 at the next edge.
